fetch_pc_gen: RTL and testbench

Fetch-stage PC generator sitting directly downstream of the branch prediction unit (BPU). Each cycle it picks the next fetch PC from redirect, BPU prediction or sequential PC+4. It keeps an in-order queue of outstanding fetches with their predictions. It checks each fetch against the resolution from ID, raises a flush on mispredict, and drives the BPU update bus.

---
 rtl/fetch_pc_gen.sv | 161 ++++++++++++++++
 tb/tb_fetch_pc_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: chooses redirect / BPU target / PC+4, keeps an
// in-order queue of outstanding fetch predictions and checks them against ID.
module fetch_pc_gen #(
    parameter int            N        = 32,
    parameter logic [N-1:0]  RESET_PC = 32'h0000_0000,
    parameter int            QDEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_stall,
    input  logic         i_pred_taken,
    input  logic [N-1:0] i_pred_pc,
    input  logic         i_dec_valid,
    input  logic         i_dec_is_branch,
    input  logic         i_dec_taken,
    input  logic [N-1:0] i_dec_target,
    output logic [N-1:0] o_pc,
    output logic         o_fetch,
    output logic         o_q_full,
    output logic         o_flush,
    output logic         o_bpu_is_branch,
    output logic [N-1:0] o_bpu_branch_pc,
    output logic [N-1:0] o_bpu_offset_pc,
    output logic         o_bpu_taken
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [N-1:0]  PC_STEP  = N'(3'd4);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

    logic [N-1:0]  q_pc_r         [QDEPTH];
    logic          q_pred_taken_r [QDEPTH];
    logic [N-1:0]  q_pred_pc_r    [QDEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic          full_r;
    logic [N-1:0]  pc_r;
    logic          flush_r;
    logic          bpu_is_branch_r;
    logic [N-1:0]  bpu_branch_pc_r;
    logic [N-1:0]  bpu_offset_pc_r;
    logic          bpu_taken_r;

    logic [N-1:0]  head_pc_s;
    logic          head_pred_taken_s;
    logic [N-1:0]  head_pred_pc_s;
    logic          actual_taken_s;
    logic          pop_s;
    logic          push_s;
    logic          mispredict_s;
    logic [N-1:0]  correct_pc_s;
    logic [N-1:0]  next_pc_s;
    logic [CW-1:0] count_next_s;

    // Resolution check of the queue head, fetch acceptance and next-PC choice
    always_comb begin
        head_pc_s         = q_pc_r[head_r];
        head_pred_taken_s = q_pred_taken_r[head_r];
        head_pred_pc_s    = q_pred_pc_r[head_r];
        actual_taken_s    = i_dec_is_branch & i_dec_taken;
        pop_s             = i_dec_valid & (count_r != CNT_ZERO);

        if (pop_s) begin
            mispredict_s = (head_pred_taken_s != actual_taken_s) |
                           (head_pred_taken_s & actual_taken_s &
                            (head_pred_pc_s != i_dec_target));
        end else begin
            mispredict_s = 1'b0;
        end

        if (actual_taken_s) begin
            correct_pc_s = i_dec_target;
        end else begin
            correct_pc_s = head_pc_s + PC_STEP;
        end

        // full_r comes from the registered count, so a same-cycle pop never frees a slot
        push_s = ~i_stall & ~full_r & ~mispredict_s;

        if (i_pred_taken) begin
            next_pc_s = i_pred_pc;
        end else begin
            next_pc_s = pc_r + PC_STEP;
        end

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // PC and queue bookkeeping; a mispredict empties the queue and redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r    <= RESET_PC;
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
        end else if (mispredict_s) begin
            pc_r    <= correct_pc_s;
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= CNT_ZERO;
            full_r  <= 1'b0;
        end else begin
            if (push_s) begin
                pc_r   <= next_pc_s;
                tail_r <= tail_r + PTR_ONE;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_CNT);
        end
    end

    // Entry payload storage; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (push_s) begin
            q_pc_r[tail_r]         <= pc_r;
            q_pred_taken_r[tail_r] <= i_pred_taken;
            q_pred_pc_r[tail_r]    <= i_pred_pc;
        end
    end

    // Flush pulse and BPU update bus; update data holds between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_r         <= 1'b0;
            bpu_is_branch_r <= 1'b0;
            bpu_branch_pc_r <= {N{1'b0}};
            bpu_offset_pc_r <= {N{1'b0}};
            bpu_taken_r     <= 1'b0;
        end else begin
            flush_r         <= mispredict_s;
            bpu_is_branch_r <= pop_s & i_dec_is_branch;
            if (pop_s & i_dec_is_branch) begin
                bpu_branch_pc_r <= head_pc_s;
                bpu_offset_pc_r <= i_dec_target;
                bpu_taken_r     <= i_dec_taken;
            end
        end
    end

    assign o_pc            = pc_r;
    assign o_fetch         = push_s;
    assign o_q_full        = full_r;
    assign o_flush         = flush_r;
    assign o_bpu_is_branch = bpu_is_branch_r;
    assign o_bpu_branch_pc = bpu_branch_pc_r;
    assign o_bpu_offset_pc = bpu_offset_pc_r;
    assign o_bpu_taken     = bpu_taken_r;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: a queue-based reference model predicts
// registered state and BPU updates; monitors compare them as the DUT presents them.
module tb_fetch_pc_gen;
    localparam int          N        = 32;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_stall = 1'b0;
    logic        i_pred_taken = 1'b0;
    logic [31:0] i_pred_pc = 32'h0;
    logic        i_dec_valid = 1'b0;
    logic        i_dec_is_branch = 1'b0;
    logic        i_dec_taken = 1'b0;
    logic [31:0] i_dec_target = 32'h0;
    logic [31:0] o_pc;
    logic        o_fetch;
    logic        o_q_full;
    logic        o_flush;
    logic        o_bpu_is_branch;
    logic [31:0] o_bpu_branch_pc;
    logic [31:0] o_bpu_offset_pc;
    logic        o_bpu_taken;

    fetch_pc_gen #(.N(N), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall),
        .i_pred_taken(i_pred_taken), .i_pred_pc(i_pred_pc),
        .i_dec_valid(i_dec_valid), .i_dec_is_branch(i_dec_is_branch),
        .i_dec_taken(i_dec_taken), .i_dec_target(i_dec_target),
        .o_pc(o_pc), .o_fetch(o_fetch), .o_q_full(o_q_full), .o_flush(o_flush),
        .o_bpu_is_branch(o_bpu_is_branch), .o_bpu_branch_pc(o_bpu_branch_pc),
        .o_bpu_offset_pc(o_bpu_offset_pc), .o_bpu_taken(o_bpu_taken)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] pc; logic pt; logic [31:0] pp; } fentry_t;
    typedef struct packed {
        logic [31:0] pc; logic flush; logic full;
        logic [31:0] bpc; logic [31:0] btgt; logic btk;
    } state_t;
    typedef struct packed { logic [31:0] due; logic [31:0] pc; logic [31:0] tgt; logic tk; } bpu_t;

    fentry_t     m_q[$];
    state_t      state_q[$];
    bpu_t        bpu_q[$];
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_bpc = 32'h0;
    logic [31:0] m_btgt = 32'h0;
    logic        m_btk = 1'b0;
    logic [31:0] cyc = 32'h0;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock of stimulus; the model advances and queues what the DUT must show next.
    task automatic step(input logic r, input logic s, input logic pt, input logic [31:0] pp,
                        input logic dv, input logic br, input logic tk, input logic [31:0] tgt);
        fentry_t     h;
        state_t      st;
        bpu_t        b;
        logic        act, mis, fe, pop;
        logic [31:0] c;
        @(negedge clk);
        rst = r; i_stall = s; i_pred_taken = pt; i_pred_pc = pp;
        i_dec_valid = dv; i_dec_is_branch = br; i_dec_taken = tk; i_dec_target = tgt;
        #1;
        if (r) begin
            m_pc = RESET_PC;
            m_q.delete();
            m_bpc = 32'h0; m_btgt = 32'h0; m_btk = 1'b0;
            mis = 1'b0;
        end else begin
            pop = dv && (m_q.size() > 0);
            mis = 1'b0; act = br && tk; c = 32'h0; h = '0;
            if (pop) begin
                h   = m_q[0];
                mis = (h.pt != act) || (h.pt && act && (h.pp != tgt));
                c   = act ? tgt : h.pc + 32'd4;
            end
            fe = !s && (m_q.size() < QDEPTH) && !mis;
            check("o_fetch", {31'b0, o_fetch}, {31'b0, fe});
            if (pop && br) begin
                b.due = cyc + 32'd1; b.pc = h.pc; b.tgt = tgt; b.tk = tk;
                bpu_q.push_back(b);
                m_bpc = h.pc; m_btgt = tgt; m_btk = tk;
            end
            if (mis) begin
                m_q.delete();
                m_pc = c;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (fe) begin
                    h.pc = m_pc; h.pt = pt; h.pp = pp;
                    m_q.push_back(h);
                    m_pc = pt ? pp : m_pc + 32'd4;
                end
            end
        end
        st.pc = m_pc; st.flush = mis; st.full = (m_q.size() == QDEPTH);
        st.bpc = m_bpc; st.btgt = m_btgt; st.btk = m_btk;
        state_q.push_back(st);
    endtask

    task automatic idle(input logic s);
        step(1'b0, s, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic rand_cycle();
        logic        s, pt, dv, br, tk;
        logic [31:0] pp, tgt;
        s   = ($urandom_range(0, 3) == 0);
        pt  = ($urandom_range(0, 2) == 0);
        pp  = $urandom & 32'hFFFF_FFFC;
        dv  = ($urandom_range(0, 1) == 1);
        br  = ($urandom_range(0, 1) == 1);
        tk  = ($urandom_range(0, 1) == 1);
        tgt = $urandom & 32'hFFFF_FFFC;
        // Mostly resolve consistently with the head's prediction so runs stay long
        if (m_q.size() > 0 && $urandom_range(0, 4) != 0) begin
            if (m_q[0].pt) begin
                br = 1'b1; tk = 1'b1; tgt = m_q[0].pp;
            end else if (br) begin
                tk = 1'b0;
            end
        end
        step(($urandom_range(0, 99) == 0), s, pt, pp, dv, br, tk, tgt);
    endtask

    // Monitor: registered state every cycle, BPU updates whenever the strobe is up
    initial begin
        state_t st;
        bpu_t   b;
        forever begin
            @(posedge clk);
            #1;
            if (state_q.size() > 0) begin
                st = state_q.pop_front();
                check("o_pc", o_pc, st.pc);
                check("o_flush", {31'b0, o_flush}, {31'b0, st.flush});
                check("o_q_full", {31'b0, o_q_full}, {31'b0, st.full});
                check("o_bpu_branch_pc", o_bpu_branch_pc, st.bpc);
                check("o_bpu_offset_pc", o_bpu_offset_pc, st.btgt);
                check("o_bpu_taken", {31'b0, o_bpu_taken}, {31'b0, st.btk});
            end
            while (bpu_q.size() > 0 && bpu_q[0].due < cyc) begin
                b = bpu_q.pop_front();
                n_checks++;
                $display("FAIL bpu_missing: got no strobe expected update pc %h (due %0d)", b.pc, b.due);
            end
            if (o_bpu_is_branch) begin
                if (bpu_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL bpu_strobe: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    b = bpu_q.pop_front();
                    check("bpu_cycle", cyc, b.due);
                    check("bpu_pc", o_bpu_branch_pc, b.pc);
                    check("bpu_target", o_bpu_offset_pc, b.tgt);
                    check("bpu_taken", {31'b0, o_bpu_taken}, {31'b0, b.tk});
                end
            end
        end
    end

    initial begin
        // Sequential fetch fills the queue and then holds
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) idle(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(1'b1);

        // Correctly predicted taken branch at 8 -> 0x40
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40);
        idle(1'b1);

        // Direction mispredict at 0x10 with two younger entries
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h80);
        idle(1'b1);

        // Target mispredict 0x40 vs 0x44
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h44);
        idle(1'b1);

        // Non-branch predicted taken at 0x20
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h60, 1'b1, 1'b1, 1'b1, 32'h20);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(1'b1);
        idle(1'b1);

        // Stall holds fetch, yet a mispredict still redirects
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        idle(1'b1);

        // Resolution on an empty queue is ignored
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h99C);
        idle(1'b1);

        // PC wrap, then reset with three entries outstanding
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1'b1);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Randomized traffic
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2000; i++) rand_cycle();
        idle(1'b1);

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (bpu_q.size() == 0 && state_q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d bpu and %0d state entries left expected 0", bpu_q.size(), state_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
